// File: rtl/dlfloat_pkg.sv
// Shared DLfloat16 constants and accumulator state encoding.
// Pure declarations, no logic or latency.
// No handshake; consumers apply their own flow control.
package dlfloat_pkg;

  localparam int DLF_W = 16;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WAIT,
    DONE
  } acc_state_t;

  // Only the all-ones pattern is treated as NaN; fields are never decoded.
  function automatic logic is_nan(input logic [DLF_W-1:0] v);
    return (v == DLF_NAN);
  endfunction

endpackage

// File: rtl/dlfloat_accum_seq.sv
// Stream reducer: feeds each element plus the running sum through an external adder.
// Latency: one edge from a single-element accept, two edges from the last ACCUM accept.
// Backpressure: in_ready drops during the adder turnaround cycle and while a result waits on out_ready.
module dlfloat_accum_seq
  import dlfloat_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DLF_W-1:0] in_data,
  input  logic             in_last,
  output logic [DLF_W-1:0] add_a,
  output logic [DLF_W-1:0] add_b,
  input  logic [DLF_W-1:0] add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DLF_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_trunc
);

  acc_state_t       state;
  logic [DLF_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             nan_f;
  logic             trunc_f;
  logic             last_f;

  logic             in_xfer;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_max;
  logic             in_nan;
  logic             single_max;

  // The adder sees the running sum and the offered element every cycle;
  // only the sample taken on an accepted ACCUM cycle comes back as add_c.
  assign add_a      = acc;
  assign add_b      = in_data;
  assign in_ready   = !rst && ((state == IDLE) || (state == ACCUM));
  assign in_xfer    = in_valid && in_ready;
  assign cnt_nxt    = cnt + CNT_W'(1);
  assign at_max     = (cnt_nxt == CNT_W'(MAX_LEN));
  assign in_nan     = is_nan(in_data);
  assign single_max = (MAX_LEN == 1);

  // Sequencer: state, running sum, flags and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= DLF_ZERO;
      cnt       <= '0;
      nan_f     <= 1'b0;
      trunc_f   <= 1'b0;
      last_f    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= DLF_ZERO;
      out_count <= '0;
      out_nan   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            // First element bypasses the adder.
            acc     <= in_data;
            cnt     <= CNT_W'(1);
            nan_f   <= in_nan;
            trunc_f <= !in_last && single_max;
            if (in_last || single_max) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_nan ? DLF_NAN : in_data;
              out_count <= CNT_W'(1);
              out_nan   <= in_nan;
              out_trunc <= !in_last && single_max;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            cnt     <= cnt_nxt;
            nan_f   <= nan_f || in_nan;
            last_f  <= in_last || at_max;
            trunc_f <= !in_last && at_max;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // add_c now holds the sum sampled on the accepting edge.
          acc <= add_c;
          if (last_f) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= nan_f ? DLF_NAN : add_c;
            out_count <= cnt;
            out_nan   <= nan_f;
            out_trunc <= trunc_f;
          end else begin
            state <= ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            nan_f     <= 1'b0;
            trunc_f   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= DLF_ZERO;
            out_count <= '0;
            out_nan   <= 1'b0;
            out_trunc <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_accum_seq.sv
// Scoreboard bench for dlfloat_accum_seq with a registered integer-add stub adder.
module tb_dlfloat_accum_seq;

  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic [15:0]   add_c;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_nan;
  logic          out_trunc;

  always #5 clk = ~clk;

  dlfloat_accum_seq #(.MAX_LEN(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_nan   (out_nan),
    .out_trunc (out_trunc)
  );

  // Stub adder: plain 16-bit integer sum, registered.
  always_ff @(posedge clk) add_c <= add_a + add_b;

  typedef struct packed {
    logic [15:0]   d;
    logic [CW-1:0] c;
    logic          n;
    logic          t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sd[8];
  logic        sl[8];
  logic        rdy_log[$];
  logic [31:0] op_log[$];

  function automatic exp_t mk(input logic [15:0] d, input int c, input logic n, input logic t);
    exp_t e;
    e.d = d;
    e.c = CW'(c);
    e.n = n;
    e.t = t;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Offer sd[0..n-1] back to back; returns #1 after the last accepting edge.
  task automatic drive(input int n);
    int  guard;
    bit  done;
    for (int i = 0; i < n; i++) begin
      guard    = 0;
      done     = 0;
      in_valid = 1'b1;
      in_data  = sd[i];
      in_last  = sl[i];
      while (!done) begin
        @(negedge clk);
        rdy_log.push_back(in_ready);
        if (in_ready) begin
          op_log.push_back({add_a, add_b});
          done = 1;
        end else begin
          guard++;
          if (guard > 50) begin
            n_vec++;
            n_err++;
            $display("FAIL drive_timeout elem %0d: in_ready 0, want 1", i);
            done = 1;
          end
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait until every expected result is consumed and the block is idle.
  task automatic settle();
    int g;
    g = 0;
    while ((sb.size() != 0 || !in_ready) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL settle_timeout: pending %0d, in_ready %0b, want 0 and 1", sb.size(), in_ready);
    end
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got data %0h, want no output", out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data",  32'(out_data),  32'(mon_e.d));
          check("out_count", 32'(out_count), 32'(mon_e.c));
          check("out_nan",   32'(out_nan),   32'(mon_e.n));
          check("out_trunc", 32'(out_trunc), 32'(mon_e.t));
        end
      end
    end
  end

  // Stimulus
  initial begin
    int g;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_flags", {30'd0, out_nan, out_trunc}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single element: result one edge after accept
    sd[0] = 16'h3E00; sl[0] = 1'b1;
    sb.push_back(mk(16'h3E00, 1, 1'b0, 1'b0));
    drive(1);
    check("single_latency", 32'(out_valid), 1);
    settle();

    // Three-element sum: operand sampling, ready pattern, latency
    rdy_log.delete();
    op_log.delete();
    sd[0] = 16'h0001; sl[0] = 1'b0;
    sd[1] = 16'h0002; sl[1] = 1'b0;
    sd[2] = 16'h0003; sl[2] = 1'b1;
    sb.push_back(mk(16'h0006, 3, 1'b0, 1'b0));
    drive(3);
    check("sum3_wait_no_valid", 32'(out_valid), 0);
    @(negedge clk);
    rdy_log.push_back(in_ready);
    @(posedge clk);
    #1;
    check("sum3_latency", 32'(out_valid), 1);
    check("sum3_rdy_len", rdy_log.size(), 5);
    if (rdy_log.size() >= 5)
      check("sum3_rdy_pattern",
            {27'd0, rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3], rdy_log[4]}, 5'b11010);
    check("sum3_ops_len", op_log.size(), 3);
    if (op_log.size() >= 3) begin
      check("sum3_ops_1", op_log[1], {16'h0001, 16'h0002});
      check("sum3_ops_2", op_log[2], {16'h0003, 16'h0003});
    end
    settle();

    // NaN in the middle of a stream
    sd[0] = 16'h0010; sl[0] = 1'b0;
    sd[1] = 16'hFFFF; sl[1] = 1'b0;
    sd[2] = 16'h0001; sl[2] = 1'b1;
    sb.push_back(mk(16'hFFFF, 3, 1'b1, 1'b0));
    drive(3);
    settle();

    // Truncation at MAX_LEN=4; remaining elements form a new stream
    for (int i = 0; i < 6; i++) begin
      sd[i] = 16'h0001;
      sl[i] = 1'b0;
    end
    sd[6] = 16'h0001; sl[6] = 1'b1;
    sb.push_back(mk(16'h0004, 4, 1'b0, 1'b1));
    sb.push_back(mk(16'h0003, 3, 1'b0, 1'b0));
    drive(7);
    settle();

    // Output stall: five cycles held, transfer on the sixth
    out_ready = 1'b0;
    sd[0] = 16'h0007; sl[0] = 1'b0;
    sd[1] = 16'h0008; sl[1] = 1'b1;
    sb.push_back(mk(16'h000F, 2, 1'b0, 1'b0));
    drive(2);
    g = 0;
    while (!out_valid && g < 10) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("stall_valid_seen", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid",    32'(out_valid), 1);
      check("stall_data",     32'(out_data),  32'h000F);
      check("stall_count",    32'(out_count), 2);
      check("stall_flags",    {30'd0, out_nan, out_trunc}, 0);
      check("stall_in_ready", 32'(in_ready),  0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_idle_ready", 32'(in_ready),  1);
    check("stall_idle_valid", 32'(out_valid), 0);
    settle();

    // Reset during WAIT discards the partial sum
    sd[0] = 16'h0001; sl[0] = 1'b0;
    sd[1] = 16'h0002; sl[1] = 1'b0;
    drive(2);
    rst = 1'b1;
    #1;
    check("midrst_valid",    32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready),  0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_idle", 32'(in_ready), 1);
    sd[0] = 16'h0005; sl[0] = 1'b1;
    sb.push_back(mk(16'h0005, 1, 1'b0, 1'b0));
    drive(1);
    settle();

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
